// File: rtl/responder_stage4_sched.sv
// responder_stage4_sched: stage-4 responder scheduler.
// Arbitrates round-robin across NUM_CH header/data queue pairs. Each granted
// packet is either forwarded (header beat, then data beats) to the output mux
// or, for no-process headers, its data is drained silently. Notification
// locks and non-posted backpressure gate the start of new packets only.
// Ports:
//   clk, res_n                      clock, async active-low reset
//   hdr_valid/noprocess/np/len      per-channel header queue heads
//   hdr_take                        one-hot header pop
//   data_valid / data_take          per-channel data queue head / one-hot pop
//   np_stop, np_afull               block starting non-posted packets
//   noti_cond                       notification pending, block new packets
//   out_ready / out_valid/sop/eop   output beat handshake and framing
//   out_qw_cnt, out_sel             valid QW in data beat, output mux select
//   state_lock/get/data/drain       one-hot state flags (all 0 in IDLE)
module responder_stage4_sched #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LEN_W  = 5,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned QPB   = DATA_W / 64,
    localparam int unsigned QW_W  = $clog2(QPB) + 1
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic [NUM_CH-1:0]       hdr_valid,
    input  logic [NUM_CH-1:0]       hdr_noprocess,
    input  logic [NUM_CH-1:0]       hdr_np,
    input  logic [NUM_CH*LEN_W-1:0] hdr_len,
    output logic [NUM_CH-1:0]       hdr_take,
    input  logic [NUM_CH-1:0]       data_valid,
    output logic [NUM_CH-1:0]       data_take,
    input  logic                    np_stop,
    input  logic                    np_afull,
    input  logic                    noti_cond,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [QW_W-1:0]         out_qw_cnt,
    output logic [CH_W-1:0]         out_sel,
    output logic                    state_lock,
    output logic                    state_get,
    output logic                    state_data,
    output logic                    state_drain
);

    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_GET,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t            r_state, w_state_nx;
    logic [CH_W-1:0]   r_ptr, w_ptr_nx;
    logic [CH_W-1:0]   r_ch, w_ch_nx;
    logic              r_noproc, w_noproc_nx;
    logic              r_len_nz, w_len_nz_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [QW_W-1:0]   r_last_qw, w_last_qw_nx;
    logic              r_lock_seen, w_lock_seen_nx;

    logic              w_hdr_pop;
    logic [NUM_CH-1:0] w_pop_mask;
    logic [NUM_CH-1:0] w_elig;
    logic              w_gnt_ok;
    logic [CH_W-1:0]   w_gnt;
    logic [LEN_W-1:0]  w_gnt_len;
    logic [CNT_W-1:0]  w_gnt_beats;
    logic [QW_W-1:0]   w_gnt_qw;
    logic [NUM_CH-1:0] w_ch_onehot;
    logic              w_last;
    logic              w_eop_dec;
    logic              w_start;

    // A header being popped this cycle is still visible on hdr_valid; keep it
    // out of arbitration so a back-to-back grant never re-serves it.
    assign w_hdr_pop   = (r_state == S_GET) && (r_noproc || out_ready);
    assign w_pop_mask  = NUM_CH'(w_hdr_pop) << r_ch;
    assign w_elig      = hdr_valid & ~(hdr_np & {NUM_CH{np_stop | np_afull}}) & ~w_pop_mask;
    assign w_ch_onehot = NUM_CH'(1) << r_ch;
    assign w_last      = (r_cnt == CNT_W'(1));

    // Round-robin: first eligible channel at or after r_ptr, with wrap.
    always_comb begin
        int unsigned idx;
        int unsigned len_i;
        idx      = 0;
        len_i    = 0;
        w_gnt_ok = 1'b0;
        w_gnt    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NUM_CH;
            if (w_elig[idx]) begin
                w_gnt_ok = 1'b1;
                w_gnt    = CH_W'(idx);
            end
        end
        w_gnt_len   = hdr_len[int'(w_gnt)*LEN_W +: LEN_W];
        len_i       = int'(w_gnt_len);
        w_gnt_beats = CNT_W'((len_i + QPB - 1) / QPB);
        w_gnt_qw    = ((len_i % QPB) == 0) ? QW_W'(QPB) : QW_W'(len_i % QPB);
    end

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_ch        <= '0;
            r_noproc    <= 1'b0;
            r_len_nz    <= 1'b0;
            r_cnt       <= '0;
            r_last_qw   <= '0;
            r_lock_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_ch        <= w_ch_nx;
            r_noproc    <= w_noproc_nx;
            r_len_nz    <= w_len_nz_nx;
            r_cnt       <= w_cnt_nx;
            r_last_qw   <= w_last_qw_nx;
            r_lock_seen <= w_lock_seen_nx;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nx     = r_state;
        w_ptr_nx       = r_ptr;
        w_ch_nx        = r_ch;
        w_noproc_nx    = r_noproc;
        w_len_nz_nx    = r_len_nz;
        w_cnt_nx       = r_cnt;
        w_last_qw_nx   = r_last_qw;
        w_lock_seen_nx = r_lock_seen;
        hdr_take       = '0;
        data_take      = '0;
        out_valid      = 1'b0;
        out_sop        = 1'b0;
        out_eop        = 1'b0;
        out_qw_cnt     = '0;
        out_sel        = '0;
        w_eop_dec      = 1'b0;
        w_start        = 1'b0;

        case (r_state)
            S_LOCK: begin
                w_lock_seen_nx = 1'b1;
                if (r_lock_seen && !noti_cond) w_state_nx = S_IDLE;
            end
            S_GET: begin
                out_sel = r_ch;
                if (r_noproc) begin
                    hdr_take = w_ch_onehot;
                    if (r_len_nz) w_state_nx = S_DRAIN;
                    else          w_eop_dec  = 1'b1;
                end else begin
                    out_valid = 1'b1;
                    out_sop   = 1'b1;
                    out_eop   = !r_len_nz;
                    if (out_ready) begin
                        hdr_take = w_ch_onehot;
                        if (r_len_nz) w_state_nx = S_DATA;
                        else          w_eop_dec  = 1'b1;
                    end
                end
            end
            S_DATA: begin
                out_sel   = r_ch;
                out_valid = data_valid[r_ch];
                if (out_valid) begin
                    out_eop    = w_last;
                    out_qw_cnt = w_last ? r_last_qw : QW_W'(QPB);
                    if (out_ready) begin
                        data_take = w_ch_onehot;
                        w_cnt_nx  = r_cnt - CNT_W'(1);
                        w_eop_dec = w_last;
                    end
                end
            end
            S_DRAIN: begin
                if (data_valid[r_ch]) begin
                    data_take = w_ch_onehot;
                    w_cnt_nx  = r_cnt - CNT_W'(1);
                    w_eop_dec = w_last;
                end
            end
            default: ;
        endcase

        // Start decision shared by IDLE and end of packet (no idle bubble).
        if (r_state == S_IDLE || w_eop_dec) begin
            if (noti_cond) begin
                w_state_nx     = S_LOCK;
                w_lock_seen_nx = 1'b0;
            end else if (w_gnt_ok) begin
                w_start = 1'b1;
            end else begin
                w_state_nx = S_IDLE;
            end
        end

        if (w_start) begin
            w_state_nx   = S_GET;
            w_ch_nx      = w_gnt;
            w_ptr_nx     = (int'(w_gnt) == NUM_CH - 1) ? CH_W'(0) : w_gnt + CH_W'(1);
            w_noproc_nx  = hdr_noprocess[w_gnt];
            w_len_nz_nx  = |w_gnt_len;
            w_cnt_nx     = w_gnt_beats;
            w_last_qw_nx = w_gnt_qw;
        end
    end

    assign state_lock  = (r_state == S_LOCK);
    assign state_get   = (r_state == S_GET);
    assign state_data  = (r_state == S_DATA);
    assign state_drain = (r_state == S_DRAIN);

endmodule

// File: tb/tb_responder_stage4_sched.sv
// Directed bench for responder_stage4_sched: one instance at DATA_W=128 and a
// second at DATA_W=256 for the stalled-output and mid-packet reset case.
module tb_responder_stage4_sched;

    localparam logic [3:0] ST_IDLE  = 4'b0000;
    localparam logic [3:0] ST_LOCK  = 4'b1000;
    localparam logic [3:0] ST_GET   = 4'b0100;
    localparam logic [3:0] ST_DATA  = 4'b0010;
    localparam logic [3:0] ST_DRAIN = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_CH=2, DATA_W=128
    logic        res_n;
    logic [1:0]  hdr_valid, hdr_noprocess, hdr_np, hdr_take;
    logic [9:0]  hdr_len;
    logic [1:0]  data_valid, data_take;
    logic        np_stop, np_afull, noti_cond, out_ready;
    logic        out_valid, out_sop, out_eop;
    logic [1:0]  out_qw_cnt;
    logic [0:0]  out_sel;
    logic        state_lock, state_get, state_data, state_drain;

    // Instance B: NUM_CH=2, DATA_W=256
    logic        b_res_n;
    logic [1:0]  b_hdr_valid, b_hdr_take;
    logic [9:0]  b_hdr_len;
    logic [1:0]  b_data_valid, b_data_take;
    logic        b_out_ready;
    logic        b_out_valid, b_out_sop, b_out_eop;
    logic [2:0]  b_out_qw_cnt;
    logic [0:0]  b_out_sel;
    logic        b_state_lock, b_state_get, b_state_data, b_state_drain;

    int n_vec = 0;
    int n_err = 0;

    responder_stage4_sched #(.NUM_CH(2), .DATA_W(128), .LEN_W(5)) u_dut (
        .clk(clk), .res_n(res_n),
        .hdr_valid(hdr_valid), .hdr_noprocess(hdr_noprocess), .hdr_np(hdr_np),
        .hdr_len(hdr_len), .hdr_take(hdr_take),
        .data_valid(data_valid), .data_take(data_take),
        .np_stop(np_stop), .np_afull(np_afull), .noti_cond(noti_cond),
        .out_ready(out_ready), .out_valid(out_valid), .out_sop(out_sop),
        .out_eop(out_eop), .out_qw_cnt(out_qw_cnt), .out_sel(out_sel),
        .state_lock(state_lock), .state_get(state_get),
        .state_data(state_data), .state_drain(state_drain)
    );

    responder_stage4_sched #(.NUM_CH(2), .DATA_W(256), .LEN_W(5)) u_dut_w256 (
        .clk(clk), .res_n(b_res_n),
        .hdr_valid(b_hdr_valid), .hdr_noprocess(2'b00), .hdr_np(2'b00),
        .hdr_len(b_hdr_len), .hdr_take(b_hdr_take),
        .data_valid(b_data_valid), .data_take(b_data_take),
        .np_stop(1'b0), .np_afull(1'b0), .noti_cond(1'b0),
        .out_ready(b_out_ready), .out_valid(b_out_valid), .out_sop(b_out_sop),
        .out_eop(b_out_eop), .out_qw_cnt(b_out_qw_cnt), .out_sel(b_out_sel),
        .state_lock(b_state_lock), .state_get(b_state_get),
        .state_data(b_state_data), .state_drain(b_state_drain)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Compare every output of instance A against one expected vector.
    task automatic chk_a(input string t, input logic [3:0] st, input logic v,
                         input logic s, input logic e, input logic [1:0] q,
                         input logic sel, input logic [1:0] ht, input logic [1:0] dt);
        chk({t, ".state"}, 32'({state_lock, state_get, state_data, state_drain}), 32'(st));
        chk({t, ".valid"}, 32'(out_valid), 32'(v));
        chk({t, ".sop"},   32'(out_sop), 32'(s));
        chk({t, ".eop"},   32'(out_eop), 32'(e));
        chk({t, ".qw"},    32'(out_qw_cnt), 32'(q));
        chk({t, ".sel"},   32'(out_sel), 32'(sel));
        chk({t, ".htake"}, 32'(hdr_take), 32'(ht));
        chk({t, ".dtake"}, 32'(data_take), 32'(dt));
    endtask

    task automatic chk_b(input string t, input logic [3:0] st, input logic v,
                         input logic s, input logic e, input logic [2:0] q,
                         input logic [1:0] ht, input logic [1:0] dt);
        chk({t, ".state"}, 32'({b_state_lock, b_state_get, b_state_data, b_state_drain}), 32'(st));
        chk({t, ".valid"}, 32'(b_out_valid), 32'(v));
        chk({t, ".sop"},   32'(b_out_sop), 32'(s));
        chk({t, ".eop"},   32'(b_out_eop), 32'(e));
        chk({t, ".qw"},    32'(b_out_qw_cnt), 32'(q));
        chk({t, ".htake"}, 32'(b_hdr_take), 32'(ht));
        chk({t, ".dtake"}, 32'(b_data_take), 32'(dt));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        res_n = 1'b0; b_res_n = 1'b0;
        hdr_valid = '0; hdr_noprocess = '0; hdr_np = '0; hdr_len = '0;
        data_valid = '0; np_stop = 1'b0; np_afull = 1'b0; noti_cond = 1'b0;
        out_ready = 1'b0;
        b_hdr_valid = '0; b_hdr_len = '0; b_data_valid = '0; b_out_ready = 1'b0;

        @(negedge clk);
        #1 chk_a("rst", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        chk_b("rst_b", ST_IDLE, 0, 0, 0, 0, 2'b00, 2'b00);
        res_n = 1'b1; b_res_n = 1'b1;

        // 1: ch0 len=5 -> header, then 2,2,1 QW beats
        hdr_valid = 2'b01; hdr_len = {5'd0, 5'd5}; data_valid = 2'b11; out_ready = 1'b1;
        #1 chk_a("t1.idle", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step(); #1 chk_a("t1.get", ST_GET, 1, 1, 0, 0, 0, 2'b01, 2'b00);
        hdr_valid = 2'b00;
        step(); #1 chk_a("t1.d0", ST_DATA, 1, 0, 0, 2, 0, 2'b00, 2'b01);
        step(); #1 chk_a("t1.d1", ST_DATA, 1, 0, 0, 2, 0, 2'b00, 2'b01);
        step(); #1 chk_a("t1.d2", ST_DATA, 1, 0, 1, 1, 0, 2'b00, 2'b01);
        step(); #1 chk_a("t1.end", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        // 2: both channels, len=0, pointer at 1 -> 1,0,1,0 back-to-back
        hdr_valid = 2'b11; hdr_len = '0;
        step(); #1 chk_a("t2.p0", ST_GET, 1, 1, 1, 0, 1, 2'b10, 2'b00);
        step(); #1 chk_a("t2.p1", ST_GET, 1, 1, 1, 0, 0, 2'b01, 2'b00);
        step(); #1 chk_a("t2.p2", ST_GET, 1, 1, 1, 0, 1, 2'b10, 2'b00);
        step(); #1 chk_a("t2.p3", ST_GET, 1, 1, 1, 0, 0, 2'b01, 2'b00);
        hdr_valid = 2'b00;
        step(); #1 chk_a("t2.end", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        // 3: ch1 noprocess len=4 -> one header pop, two silent data pops
        hdr_valid = 2'b10; hdr_noprocess = 2'b10; hdr_len = {5'd4, 5'd0};
        step(); #1 chk_a("t3.get", ST_GET, 0, 0, 0, 0, 1, 2'b10, 2'b00);
        hdr_valid = 2'b00;
        step(); #1 chk_a("t3.dr0", ST_DRAIN, 0, 0, 0, 0, 0, 2'b00, 2'b10);
        step(); #1 chk_a("t3.dr1", ST_DRAIN, 0, 0, 0, 0, 0, 2'b00, 2'b10);
        step(); #1 chk_a("t3.end", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        hdr_noprocess = 2'b00;

        // 4: pointer now 0; ch0 non-posted blocked by np_afull, ch1 served
        hdr_valid = 2'b11; hdr_np = 2'b01; np_afull = 1'b1; hdr_len = '0;
        step(); #1 chk_a("t4.ch1", ST_GET, 1, 1, 1, 0, 1, 2'b10, 2'b00);
        hdr_valid = 2'b01;
        step(); #1 chk_a("t4.wait", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        np_afull = 1'b0;
        step(); #1 chk_a("t4.ch0", ST_GET, 1, 1, 1, 0, 0, 2'b01, 2'b00);
        hdr_valid = 2'b00; hdr_np = 2'b00;
        step(); #1 chk_a("t4.end", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        // 5: noti_cond raised mid-DATA; packet completes, then LOCK >= 2 cycles
        hdr_valid = 2'b01; hdr_len = {5'd0, 5'd4};
        step(); #1 chk_a("t5.get", ST_GET, 1, 1, 0, 0, 0, 2'b01, 2'b00);
        step(); #1 chk_a("t5.d0", ST_DATA, 1, 0, 0, 2, 0, 2'b00, 2'b01);
        noti_cond = 1'b1;
        step(); #1 chk_a("t5.d1", ST_DATA, 1, 0, 1, 2, 0, 2'b00, 2'b01);
        step(); #1 chk_a("t5.l0", ST_LOCK, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step(); #1 chk_a("t5.l1", ST_LOCK, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step(); #1 chk_a("t5.l2", ST_LOCK, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        noti_cond = 1'b0;
        step(); #1 chk_a("t5.idle", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step(); #1 chk_a("t5.get2", ST_GET, 1, 1, 0, 0, 0, 2'b01, 2'b00);
        hdr_valid = 2'b00;
        step(); #1 chk_a("t5.e0", ST_DATA, 1, 0, 0, 2, 0, 2'b00, 2'b01);
        step(); #1 chk_a("t5.e1", ST_DATA, 1, 0, 1, 2, 0, 2'b00, 2'b01);
        step(); #1 chk_a("t5.end", ST_IDLE, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        // 6: DATA_W=256, len=8, stalled output, then reset mid-DATA
        b_hdr_valid = 2'b01; b_hdr_len = {5'd0, 5'd8}; b_data_valid = 2'b11; b_out_ready = 1'b1;
        step(); #1 chk_b("t6.get", ST_GET, 1, 1, 0, 0, 2'b01, 2'b00);
        b_hdr_valid = 2'b00;
        step(); b_out_ready = 1'b0;
        #1 chk_b("t6.stall0", ST_DATA, 1, 0, 0, 4, 2'b00, 2'b00);
        step(); b_out_ready = 1'b1;
        #1 chk_b("t6.d0", ST_DATA, 1, 0, 0, 4, 2'b00, 2'b01);
        step(); b_out_ready = 1'b0;
        #1 chk_b("t6.stall1", ST_DATA, 1, 0, 1, 4, 2'b00, 2'b00);
        b_res_n = 1'b0;
        #1 chk_b("t6.rst", ST_IDLE, 0, 0, 0, 0, 2'b00, 2'b00);
        step(); b_res_n = 1'b1; b_out_ready = 1'b1;
        #1 chk_b("t6.post0", ST_IDLE, 0, 0, 0, 0, 2'b00, 2'b00);
        step(); #1 chk_b("t6.post1", ST_IDLE, 0, 0, 0, 0, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
